// File: rtl/up2_io_pkg.sv
// Shared definitions for the up2 switch/LED peripheral: register map and
// debounce counter sizing.
package up2_io_pkg;

  localparam logic [1:0] ADDR_SW_IN   = 2'd0;
  localparam logic [1:0] ADDR_LED_OUT = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN  = 2'd2;
  localparam logic [1:0] ADDR_IRQ_PEND = 2'd3;

  // Counter only has to reach cycles-1, so clog2(cycles) bits suffice.
  function automatic int unsigned cnt_width(int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/up2_io_if.sv
// Core-side register bus of the up2 switch/LED peripheral, including the
// level interrupt back to the core.
interface up2_io_if #(
  parameter int unsigned DATA_W = 8
);

  logic              sel;
  logic              wr;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  modport master (
    output sel, wr, addr, wdata,
    input  rdata, irq
  );

  modport slave (
    input  sel, wr, addr, wdata,
    output rdata, irq
  );

endinterface

// File: rtl/up2_io_debounce.sv
// One switch input: 2-flop synchroniser followed by a debouncer when
// UP2_IO_DEBOUNCE_EN is defined, otherwise the synchroniser output is the stable bit.
module up2_io_debounce
  import up2_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic stable_o
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef UP2_IO_DEBOUNCE_EN
  localparam int unsigned CntW = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  // Debounce length is irrelevant without the debouncer.
  logic unused_db_cycles;
  assign unused_db_cycles = ^DB_CYCLES;
  assign stable_o = sync2_q;
`endif

endmodule

// File: rtl/up2_io.sv
// up2 switch/LED peripheral: register file, change-interrupt logic and read mux.
// Debouncing of the switch inputs is compiled in with UP2_IO_DEBOUNCE_EN.
module up2_io
  import up2_io_pkg::*;
#(
  parameter int unsigned NUM_SW    = 3,
  parameter int unsigned NUM_LED   = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SW-1:0]  sw,
  output logic [NUM_LED-1:0] led,
  up2_io_if.slave            bus
);

  logic [NUM_SW-1:0] stable;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    up2_io_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .sw_i    (sw[i]),
      .stable_o(stable[i])
    );
  end

  logic [NUM_SW-1:0]  stable_prev_q, stable_prev_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_SW-1:0]  irq_en_q, irq_en_d;
  logic [NUM_SW-1:0]  irq_pend_q, irq_pend_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic [NUM_SW-1:0]  pend_set, pend_clr;
  logic               wr_en, rd_en;

  always_comb begin
    stable_prev_d = stable;
    led_d         = led_q;
    irq_en_d      = irq_en_q;
    pend_clr      = '0;
    rdata_d       = rdata_q;
    wr_en         = bus.sel & bus.wr;
    rd_en         = bus.sel & ~bus.wr;
    pend_set      = (stable ^ stable_prev_q) & irq_en_q;

    if (wr_en) begin
      case (bus.addr)
        ADDR_LED_OUT:  led_d    = bus.wdata[NUM_LED-1:0];
        ADDR_IRQ_EN:   irq_en_d = bus.wdata[NUM_SW-1:0];
        ADDR_IRQ_PEND: pend_clr = bus.wdata[NUM_SW-1:0];
        default: ;
      endcase
    end

    // Set is applied after clear so a coincident change is never lost.
    irq_pend_d = (irq_pend_q & ~pend_clr) | pend_set;

    // Reads see pre-update register values.
    if (rd_en) begin
      case (bus.addr)
        ADDR_SW_IN:    rdata_d = DATA_W'(stable);
        ADDR_LED_OUT:  rdata_d = DATA_W'(led_q);
        ADDR_IRQ_EN:   rdata_d = DATA_W'(irq_en_q);
        ADDR_IRQ_PEND: rdata_d = DATA_W'(irq_pend_q);
        default:       rdata_d = '0;
      endcase
    end

    irq_d = |(irq_pend_q & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_prev_q <= '0;
      led_q         <= '0;
      irq_en_q      <= '0;
      irq_pend_q    <= '0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable_prev_d;
      led_q         <= led_d;
      irq_en_q      <= irq_en_d;
      irq_pend_q    <= irq_pend_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
    end
  end

  assign led       = led_q;
  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_up2_io.sv
// Scoreboard bench for up2_io: reads push expected data, a monitor checks rdata
// one cycle after each sampled read. Works with or without UP2_IO_DEBOUNCE_EN.
module tb_up2_io;

  localparam int unsigned DbCycles = 4;
`ifdef UP2_IO_DEBOUNCE_EN
  localparam int Lat = 2 + DbCycles;
`else
  localparam int Lat = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic [4:0] led;

  up2_io_if #(.DATA_W(8)) bus ();

  up2_io #(
    .NUM_SW   (3),
    .NUM_LED  (5),
    .DATA_W   (8),
    .DB_CYCLES(DbCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw),
    .led(led),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    bus.sel   = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    cyc(1);
    bus.sel = 1'b0;
    bus.wr  = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [7:0] exp, input string name);
    rd_exp_t e;
    e.exp     = exp;
    e.name    = name;
    rd_q.push_back(e);
    bus.sel   = 1'b1;
    bus.wr    = 1'b0;
    bus.addr  = a;
    cyc(1);
    bus.sel = 1'b0;
  endtask

  // Monitor: a read sampled on an edge presents rdata right after that edge.
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (bus.sel === 1'b1 && bus.wr === 1'b0) begin
        #2;
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_read: got %h expected none", bus.rdata);
        end else begin
          e = rd_q.pop_front();
          chk(e.name, bus.rdata, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    sw        = 3'b111;
    bus.sel   = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 8'h00;

    // Reset with switches held high.
    cyc(2);
    chk("rst_led", {3'b0, led}, 8'h00);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_irq", {7'b0, bus.irq}, 8'h00);
    rst = 1'b0;
    rd_reg(2'd0, 8'h00, "sw_in_after_rst");
    cyc(Lat + 2);
    rd_reg(2'd0, 8'h07, "sw_in_settled");
    rd_reg(2'd3, 8'h00, "pend_after_rst");
    chk("irq_after_rst", {7'b0, bus.irq}, 8'h00);

    // LED register and read-only SW_IN.
    wr_reg(2'd1, 8'hFF);
    chk("led_write", {3'b0, led}, 8'h1F);
    rd_reg(2'd1, 8'h1F, "led_readback");
    wr_reg(2'd0, 8'h00);
    rd_reg(2'd0, 8'h07, "sw_in_ro");

    sw = 3'b110;
    cyc(Lat + 2);
    rd_reg(2'd0, 8'h06, "sw_in_110");

`ifdef UP2_IO_DEBOUNCE_EN
    // Glitch of DB_CYCLES-1 samples must be filtered.
    sw[0] = 1'b1;
    cyc(3);
    sw[0] = 1'b0;
    cyc(10);
    rd_reg(2'd0, 8'h06, "glitch_filtered");
`endif

    // Exact latency: read sampled on edge k after the pin change.
    sw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      rd_reg(2'd0, (k >= Lat + 1) ? 8'h07 : 8'h06, $sformatf("latency_k%0d", k));
    end

`ifndef UP2_IO_DEBOUNCE_EN
    // Single-cycle low pulse on sw[2] passes straight through.
    sw[2] = 1'b0;
    rd_reg(2'd0, 8'h07, "pulse_k1");
    sw[2] = 1'b1;
    rd_reg(2'd0, 8'h07, "pulse_k2");
    rd_reg(2'd0, 8'h03, "pulse_k3");
    rd_reg(2'd0, 8'h07, "pulse_k4");
    cyc(2);
`endif

    // Interrupt enable masking of unused bits.
    wr_reg(2'd2, 8'hFF);
    rd_reg(2'd2, 8'h07, "irq_en_mask");
    wr_reg(2'd2, 8'h02);
    rd_reg(2'd3, 8'h00, "pend_before_toggle");

    sw = 3'b101;
    cyc(Lat + 1);
    chk("irq_not_yet", {7'b0, bus.irq}, 8'h00);
    cyc(1);
    chk("irq_set", {7'b0, bus.irq}, 8'h01);
    rd_reg(2'd3, 8'h02, "pend_bit1");

    sw = 3'b100;
    cyc(Lat + 3);
    rd_reg(2'd3, 8'h02, "pend_bit0_masked");

    wr_reg(2'd3, 8'h02);
    cyc(1);
    chk("irq_cleared", {7'b0, bus.irq}, 8'h00);
    rd_reg(2'd3, 8'h00, "pend_cleared");

    // Disabling does not clear pending.
    sw = 3'b110;
    cyc(Lat + 2);
    chk("irq_again", {7'b0, bus.irq}, 8'h01);
    wr_reg(2'd2, 8'h00);
    cyc(1);
    chk("irq_disabled", {7'b0, bus.irq}, 8'h00);
    rd_reg(2'd3, 8'h02, "pend_kept");
    wr_reg(2'd2, 8'h02);
    wr_reg(2'd3, 8'h02);
    cyc(1);
    chk("irq_cleared2", {7'b0, bus.irq}, 8'h00);

    // W1C on the same edge as a pending set: set wins.
    sw = 3'b100;
    cyc(Lat);
    wr_reg(2'd3, 8'h02);
    cyc(1);
    chk("collision_irq", {7'b0, bus.irq}, 8'h01);
    rd_reg(2'd3, 8'h02, "collision_pend");

    for (int i = 0; i < 20 && rd_q.size() != 0; i++) cyc(1);
    if (rd_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d outstanding reads expected 0", rd_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/up2_io.md
# up2_io

Parametrised switch/LED I/O peripheral for the next-generation up2 core. It replaces the fixed three-switch, five-LED wiring with NUM_SW synchronised and optionally debounced inputs and NUM_LED registered outputs. Both sit behind a four-register memory-mapped bus, and a per-bit change-interrupt is raised to the core. It sits between the board pins and the core's data bus, alongside the UART.

## Interface
Parameters:
- NUM_SW, 3, number of switch inputs (1..DATA_W)
- NUM_LED, 5, number of LED outputs (1..DATA_W)
- DATA_W, 8, bus data width
- DB_CYCLES, 1000, consecutive stable cycles required before a debounced input updates (>=2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sw  input  NUM_SW  asynchronous switch pins
- led  output  NUM_LED  LED drive, registered
- sel  input  1  bus access strobe, one cycle per access
- wr  input  1  1 = write, 0 = read (qualified by sel)
- addr  input  2  register index
- wdata  input  DATA_W  write data
- rdata  output  DATA_W  read data, registered
- irq  output  1  interrupt request, registered, level

## Operation
- Registers (addr): 0 SW_IN (RO, debounced state), 1 LED_OUT (RW), 2 IRQ_EN (RW, bit i enables sw[i]), 3 IRQ_PEND (read; write-1-to-clear).
- Bits above NUM_SW (SW_IN/IRQ_EN/IRQ_PEND) or NUM_LED (LED_OUT) read 0; writes to them are ignored. Writes to SW_IN are ignored.
- Input path per bit: 2-flop synchroniser -> debouncer -> stable bit -> change detector (stable != previous stable).
- Debouncer: a counter is cleared whenever the synced value equals stable. Otherwise it increments. When it reaches DB_CYCLES-1 with the synced value still differing, stable takes the synced value and the counter clears. A glitch shorter than DB_CYCLES cycles never reaches stable.
- Pending: IRQ_PEND[i] sets on any change of stable[i] (either edge) while IRQ_EN[i]=1.
- Clearing: a write to IRQ_PEND clears the bits where wdata=1. If a set and a clear hit the same bit in the same cycle, set wins.
- Clearing IRQ_EN[i] does not clear IRQ_PEND[i].
- irq next cycle = |(IRQ_PEND & IRQ_EN).
- Reset values: led=0, rdata=0, irq=0, all registers, synchronisers, stable bits and counters = 0.
- Reset mid-debounce discards the count. If a pin is held high through reset, stable rises after the full latency. No pending bit sets from this because IRQ_EN=0.

## Timing
- Write: the register updates on the clk edge where sel&wr is sampled. led reflects LED_OUT the same edge.
- Read: rdata is valid the cycle after sel&!wr and holds until the next read. Reading has no side effects.
- sw edge -> SW_IN update: 2 sync cycles + DB_CYCLES cycles, with DEBOUNCE_EN compiled in.
- Stable change -> IRQ_PEND set: 1 cycle. IRQ_PEND -> irq: 1 cycle.
- A read in the same cycle as a pending set returns the pre-set value.

## Configuration
- UP2_IO_DEBOUNCE_EN defined: debouncer present as above.
- UP2_IO_DEBOUNCE_EN undefined: stable = synchroniser output, and sw -> SW_IN latency is 2 cycles. DB_CYCLES is ignored and no counters are built. All other behaviour is unchanged.

## Structure
- Shared package up2_io_pkg holds:
  - register index constants: ADDR_SW_IN=0, ADDR_LED_OUT=1, ADDR_IRQ_EN=2, ADDR_IRQ_PEND=3
  - a function giving the counter width, clog2(DB_CYCLES).
- One sub-module, up2_io_debounce: single bit, containing the synchroniser, debouncer (macro-gated) and stable output. It is instantiated NUM_SW times in a generate loop.
- The top level holds the register file, change detect, pending logic and bus read mux.

## Test plan
- Reset: assert rst 2 cycles with sw=3'b111. Check led=0, rdata=0, irq=0. After 2+DB_CYCLES cycles (DB_CYCLES=4), SW_IN reads 3'b111 and irq stays 0.
- LED write/read: write 8'hFF to LED_OUT -> led=5'b11111 next edge; readback = 8'h1F. Write to SW_IN -> SW_IN unchanged.
- Debounce, DB_CYCLES=4:
  - sw[0] high for 3 cycles then low -> SW_IN[0] stays 0.
  - sw[0] high for 10 cycles -> SW_IN[0]=1 exactly 6 cycles after the edge.
- Interrupt: IRQ_EN=8'h02, toggle sw[1] -> IRQ_PEND=8'h02 and irq=1 one cycle later. Toggling sw[0] leaves IRQ_PEND[0]=0. Write 8'h02 to IRQ_PEND -> irq=0.
- Set/clear collision: time a W1C of bit 1 on the same cycle as a stable[1] change -> IRQ_PEND[1] remains 1 and irq stays 1.
- Macro off: rebuild without UP2_IO_DEBOUNCE_EN -> a 1-cycle-wide pulse on sw[2] appears on SW_IN[2] 2 cycles later.
